// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use stalls,
// redirect squash windows and registered EX-operand forwarding selects.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_dst,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       mem_dst,
  input  logic             mem_regwrite,
  input  logic             redirect_req,
  input  logic [31:0]      redirect_pc,
  output logic             stall,
  output logic             id_bubble,
  output logic             flush_ifid,
  output logic             jump_cs,
  output logic [31:0]      next_pc,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] SquashInit = 3'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StFlush = 2'd1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sq_cnt_q, sq_cnt_d;
  logic             jump_q, jump_d;
  logic [31:0]      pc_q, pc_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;
  logic             redirect_take;
  logic             squashing;

  // Register 0 is hard-wired to zero, so it can never carry a hazard.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                     input logic we);
    return we && (src == dst) && (src != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [4:0] src,
                                         input logic [4:0] e_dst, input logic e_we,
                                         input logic e_load, input logic [4:0] m_dst,
                                         input logic m_we);
    if (use_src && reg_match(src, e_dst, e_we) && !e_load) begin
      return 2'd1;
    end else if (use_src && reg_match(src, m_dst, m_we)) begin
      return 2'd2;
    end
    return 2'd0;
  endfunction

  always_comb begin
    squashing     = (state_q == StFlush) && (sq_cnt_q != 3'd0);
    redirect_take = (state_q == StRun) && redirect_req;
    lu            = (state_q == StRun) && ex_memread && ex_regwrite &&
                    ((id_use_rs && reg_match(id_rs, ex_dst, ex_regwrite)) ||
                     (id_use_rt && reg_match(id_rt, ex_dst, ex_regwrite)));
    stall         = lu && !redirect_take;
    id_bubble     = stall || squashing;
    flush_ifid    = squashing;
  end

  always_comb begin
    state_d     = state_q;
    sq_cnt_d    = sq_cnt_q;
    jump_d      = 1'b0;
    pc_d        = pc_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      StRun: begin
        if (redirect_req) begin
          state_d  = StFlush;
          sq_cnt_d = SquashInit;
          jump_d   = 1'b1;
          pc_d     = redirect_pc;
          if (!(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end
      StFlush: begin
        if (sq_cnt_q <= 3'd1) begin
          state_d  = StRun;
          sq_cnt_d = 3'd0;
        end else begin
          sq_cnt_d = sq_cnt_q - 3'd1;
        end
      end
      default: begin
        state_d  = StRun;
        sq_cnt_d = 3'd0;
      end
    endcase

    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);

    // Selects track the instruction leaving ID; a held ID keeps them frozen.
    if (!stall) begin
      if (id_bubble) begin
        fwd_a_d = 2'd0;
        fwd_b_d = 2'd0;
      end else begin
        fwd_a_d = fwd_sel(id_use_rs, id_rs, ex_dst, ex_regwrite, ex_memread, mem_dst,
                          mem_regwrite);
        fwd_b_d = fwd_sel(id_use_rt, id_rt, ex_dst, ex_regwrite, ex_memread, mem_dst,
                          mem_regwrite);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      sq_cnt_q    <= 3'd0;
      jump_q      <= 1'b0;
      pc_q        <= 32'd0;
      fwd_a_q     <= 2'd0;
      fwd_b_q     <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sq_cnt_q    <= sq_cnt_d;
      jump_q      <= jump_d;
      pc_q        <= pc_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign jump_cs   = jump_q;
  assign next_pc   = pc_q;
  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against a
// cycle-level reference model; a CNT_W=2 copy exercises counter saturation.
module tb_pipeline_hazard_ctrl;

  localparam int FC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_dst, mem_dst;
  logic        id_use_rs, id_use_rt, ex_regwrite, ex_memread, mem_regwrite, redirect_req;
  logic [31:0] redirect_pc;

  logic        d_stall, d_bubble, d_flush, d_jump;
  logic [31:0] d_pc, d_scnt, d_fcnt;
  logic [1:0]  d_fa, d_fb, d_state;

  logic        s_stall, s_bubble, s_flush, s_jump;
  logic [31:0] s_pc;
  logic [1:0]  s_fa, s_fb, s_state, s_scnt, s_fcnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_dst(ex_dst), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .mem_dst(mem_dst), .mem_regwrite(mem_regwrite),
    .redirect_req(redirect_req), .redirect_pc(redirect_pc), .stall(d_stall),
    .id_bubble(d_bubble), .flush_ifid(d_flush), .jump_cs(d_jump), .next_pc(d_pc),
    .fwd_a(d_fa), .fwd_b(d_fb), .state(d_state), .stall_cnt(d_scnt), .flush_cnt(d_fcnt)
  );

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_dst(ex_dst), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .mem_dst(mem_dst), .mem_regwrite(mem_regwrite),
    .redirect_req(redirect_req), .redirect_pc(redirect_pc), .stall(s_stall),
    .id_bubble(s_bubble), .flush_ifid(s_flush), .jump_cs(s_jump), .next_pc(s_pc),
    .fwd_a(s_fa), .fwd_b(s_fb), .state(s_state), .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
  );

  // Reference model: squash cycles left, pending jump, last accepted target,
  // pending operand selects and unbounded event totals.
  int          m_left = 0;
  bit          m_jump = 1'b0;
  logic [31:0] m_pc = 32'd0;
  logic [1:0]  m_fa = 2'd0, m_fb = 2'd0;
  longint      m_stalls = 0, m_flushes = 0;

  function automatic bit hit(input logic [4:0] s, input logic [4:0] d, input logic we);
    return (we === 1'b1) && (s == d) && (s != 5'd0);
  endfunction

  function automatic logic [1:0] exp_sel(input logic use_src, input logic [4:0] s);
    if (use_src && hit(s, ex_dst, ex_regwrite) && !ex_memread) return 2'd1;
    if (use_src && hit(s, mem_dst, mem_regwrite)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit exp_stall();
    bit load_use;
    load_use = ex_memread && ex_regwrite &&
               ((id_use_rs && hit(id_rs, ex_dst, 1'b1)) || (id_use_rt && hit(id_rt, ex_dst, 1'b1)));
    return (m_left == 0) && !redirect_req && load_use;
  endfunction

  function automatic logic [1:0] sat2(input longint v);
    logic [63:0] t;
    t = 64'(v);
    return (v > 3) ? 2'd3 : t[1:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0; m_jump <= 1'b0; m_pc <= 32'd0; m_fa <= 2'd0; m_fb <= 2'd0;
      m_stalls <= 0; m_flushes <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1; m_jump <= 1'b0; m_fa <= 2'd0; m_fb <= 2'd0;
    end else if (redirect_req) begin
      m_left <= FC; m_jump <= 1'b1; m_pc <= redirect_pc; m_flushes <= m_flushes + 1;
      m_fa <= exp_sel(id_use_rs, id_rs); m_fb <= exp_sel(id_use_rt, id_rt);
    end else if (exp_stall()) begin
      m_stalls <= m_stalls + 1; m_jump <= 1'b0;
    end else begin
      m_jump <= 1'b0; m_fa <= exp_sel(id_use_rs, id_rs); m_fb <= exp_sel(id_use_rt, id_rt);
    end
  end

  task automatic idle();
    rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_dst = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; mem_dst = 5'd0;
    mem_regwrite = 1'b0; redirect_req = 1'b0; redirect_pc = 32'd0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b1; id_rs = 5'($urandom); id_rt = 5'($urandom); id_use_rs = 1'($urandom);
      id_use_rt = 1'($urandom); ex_dst = 5'($urandom); ex_regwrite = 1'($urandom);
      ex_memread = 1'($urandom); mem_dst = 5'($urandom); mem_regwrite = 1'($urandom);
      redirect_req = 1'($urandom); redirect_pc = $urandom;
    end
    @(negedge clk); idle(); #1;
    n_checks++; if (d_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", d_state); end
    n_checks++; if (d_jump !== 1'b0) begin n_fail++; $display("FAIL reset_jump: got %0b want 0", d_jump); end
    n_checks++; if (d_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", d_pc); end
    n_checks++; if (d_fa !== 2'd0 || d_fb !== 2'd0) begin
      n_fail++; $display("FAIL reset_fwd: got a=%0d b=%0d want 0/0", d_fa, d_fb); end
    n_checks++; if (d_stall !== 1'b0 || d_bubble !== 1'b0 || d_flush !== 1'b0) begin
      n_fail++; $display("FAIL reset_comb: got %b%b%b want 000", d_stall, d_bubble, d_flush); end
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (d_scnt !== 32'd0 || d_fcnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", d_scnt, d_fcnt); end
  endtask

  task automatic test_load_use();
    @(negedge clk); idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dst = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1; #1;
    n_checks++; if (d_stall !== 1'b1 || d_bubble !== 1'b1) begin
      n_fail++; $display("FAIL lu_stall: got %b%b want 11", d_stall, d_bubble); end
    @(negedge clk); idle();
    mem_dst = 5'd8; mem_regwrite = 1'b1; id_rs = 5'd8; id_use_rs = 1'b1; #1;
    n_checks++; if (d_stall !== 1'b0) begin n_fail++; $display("FAIL lu_one_cycle: got %b want 0", d_stall); end
    n_checks++; if (d_scnt !== 32'd1) begin n_fail++; $display("FAIL lu_count: got %0d want 1", d_scnt); end
    n_checks++; if (d_fa !== 2'd0) begin n_fail++; $display("FAIL lu_fwd_hold: got %0d want 0", d_fa); end
    @(negedge clk); idle(); #1;
    n_checks++; if (d_fa !== 2'd2) begin n_fail++; $display("FAIL lu_fwd_mem: got %0d want 2", d_fa); end
  endtask

  task automatic test_fwd_priority();
    @(negedge clk); idle();
    ex_dst = 5'd5; ex_regwrite = 1'b1; mem_dst = 5'd5; mem_regwrite = 1'b1;
    id_rt = 5'd5; id_use_rt = 1'b1; id_rs = 5'd5; #1;
    n_checks++; if (d_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_nostall: got %b want 0", d_stall); end
    @(negedge clk); id_rt = 5'd0; #1;
    n_checks++; if (d_fb !== 2'd1) begin n_fail++; $display("FAIL fwd_ex_wins: got %0d want 1", d_fb); end
    n_checks++; if (d_fa !== 2'd0) begin n_fail++; $display("FAIL fwd_unused_rs: got %0d want 0", d_fa); end
    @(negedge clk); id_rt = 5'd5; ex_regwrite = 1'b0; #1;
    n_checks++; if (d_fb !== 2'd0) begin n_fail++; $display("FAIL fwd_r0: got %0d want 0", d_fb); end
    @(negedge clk); idle(); #1;
    n_checks++; if (d_fb !== 2'd2) begin n_fail++; $display("FAIL fwd_mem: got %0d want 2", d_fb); end
  endtask

  task automatic test_redirect();
    @(negedge clk); idle(); redirect_req = 1'b1; redirect_pc = 32'h0000_0040; #1;
    n_checks++; if (d_flush !== 1'b0 || d_jump !== 1'b0) begin
      n_fail++; $display("FAIL rd_cycle0: got flush=%b jump=%b want 0/0", d_flush, d_jump); end
    @(negedge clk); idle(); #1;
    n_checks++; if (d_jump !== 1'b1 || d_pc !== 32'h40) begin
      n_fail++; $display("FAIL rd_jump: got %b/%h want 1/40", d_jump, d_pc); end
    n_checks++; if (d_flush !== 1'b1 || d_bubble !== 1'b1 || d_state !== 2'd1) begin
      n_fail++; $display("FAIL rd_flush1: got %b%b st=%0d want 11 st=1", d_flush, d_bubble, d_state); end
    n_checks++; if (d_fcnt !== 32'd1) begin n_fail++; $display("FAIL rd_fcnt: got %0d want 1", d_fcnt); end
    @(negedge clk); #1;
    n_checks++; if (d_jump !== 1'b0 || d_flush !== 1'b1 || d_bubble !== 1'b1) begin
      n_fail++; $display("FAIL rd_flush2: got j=%b %b%b want j=0 11", d_jump, d_flush, d_bubble); end
    @(negedge clk); #1;
    n_checks++; if (d_state !== 2'd0 || d_flush !== 1'b0 || d_bubble !== 1'b0) begin
      n_fail++; $display("FAIL rd_run: got st=%0d %b%b want st=0 00", d_state, d_flush, d_bubble); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dst = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1;
    redirect_req = 1'b1; redirect_pc = 32'h100; #1;
    n_checks++; if (d_stall !== 1'b0 || d_bubble !== 1'b0) begin
      n_fail++; $display("FAIL sim_nostall: got %b%b want 00", d_stall, d_bubble); end
    @(negedge clk); redirect_pc = 32'h80; #1;
    n_checks++; if (d_stall !== 1'b0 || d_jump !== 1'b1 || d_pc !== 32'h100) begin
      n_fail++; $display("FAIL sim_flush1: got s=%b j=%b pc=%h want 0/1/100", d_stall, d_jump, d_pc); end
    n_checks++; if (d_scnt !== 32'd1 || d_fcnt !== 32'd2) begin
      n_fail++; $display("FAIL sim_counts: got %0d/%0d want 1/2", d_scnt, d_fcnt); end
    @(negedge clk); idle(); #1;
    n_checks++; if (d_flush !== 1'b1 || d_pc !== 32'h100 || d_fcnt !== 32'd2) begin
      n_fail++; $display("FAIL sim_ignored: got f=%b pc=%h n=%0d want 1/100/2", d_flush, d_pc, d_fcnt); end
    @(negedge clk); redirect_req = 1'b1; redirect_pc = 32'h200; #1;
    n_checks++; if (d_state !== 2'd0) begin n_fail++; $display("FAIL b2b_run: got %0d want 0", d_state); end
    @(negedge clk); idle(); #1;
    n_checks++; if (d_jump !== 1'b1 || d_pc !== 32'h200 || d_fcnt !== 32'd3) begin
      n_fail++; $display("FAIL b2b_accept: got j=%b pc=%h n=%0d want 1/200/3", d_jump, d_pc, d_fcnt); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_flush();
    @(negedge clk); idle(); redirect_req = 1'b1; redirect_pc = 32'h300;
    @(negedge clk); idle();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); idle(); #1;
    n_checks++; if (d_state !== 2'd0 || d_flush !== 1'b0 || d_jump !== 1'b0) begin
      n_fail++; $display("FAIL rst_flush: got st=%0d f=%b j=%b want 0/0/0", d_state, d_flush, d_jump); end
    n_checks++; if (d_fcnt !== 32'd0 || d_scnt !== 32'd0 || s_fcnt !== 2'd0) begin
      n_fail++; $display("FAIL rst_cnt: got %0d/%0d/%0d want 0/0/0", d_fcnt, d_scnt, s_fcnt); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); idle();
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dst = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1;
      @(negedge clk); idle();
    end
    #1;
    n_checks++; if (s_scnt !== 2'd3) begin n_fail++; $display("FAIL sat_cnt: got %0d want 3", s_scnt); end
    n_checks++; if (d_scnt !== 32'd5) begin n_fail++; $display("FAIL wide_cnt: got %0d want 5", d_scnt); end
  endtask

  task automatic test_random();
    logic [63:0] sw, fw;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
      ex_dst = 5'($urandom_range(0, 3)); mem_dst = 5'($urandom_range(0, 3));
      ex_regwrite = ($urandom_range(0, 3) != 0); mem_regwrite = ($urandom_range(0, 3) != 0);
      ex_memread = ($urandom_range(0, 2) == 0); redirect_req = ($urandom_range(0, 7) == 0);
      redirect_pc = $urandom;
      #1;
      sw = 64'(m_stalls); fw = 64'(m_flushes);
      n_checks++; if (d_stall !== exp_stall() || s_stall !== exp_stall()) begin
        n_fail++; $display("FAIL rnd_stall@%0d: got %b/%b want %b", i, d_stall, s_stall, exp_stall()); end
      n_checks++; if (d_bubble !== (exp_stall() || m_left > 0)) begin
        n_fail++; $display("FAIL rnd_bubble@%0d: got %b want %b", i, d_bubble, exp_stall() || m_left > 0); end
      n_checks++; if (d_flush !== (m_left > 0) || d_state !== 2'(m_left > 0)) begin
        n_fail++; $display("FAIL rnd_flush@%0d: got f=%b st=%0d want %b", i, d_flush, d_state, m_left > 0); end
      n_checks++; if (d_jump !== m_jump || d_pc !== m_pc) begin
        n_fail++; $display("FAIL rnd_jump@%0d: got %b/%h want %b/%h", i, d_jump, d_pc, m_jump, m_pc); end
      n_checks++; if (d_fa !== m_fa || d_fb !== m_fb) begin
        n_fail++; $display("FAIL rnd_fwd@%0d: got %0d/%0d want %0d/%0d", i, d_fa, d_fb, m_fa, m_fb); end
      n_checks++; if (d_scnt !== sw[31:0] || d_fcnt !== fw[31:0]) begin
        n_fail++; $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", i, d_scnt, d_fcnt, sw, fw); end
      n_checks++; if (s_scnt !== sat2(m_stalls) || s_fcnt !== sat2(m_flushes)) begin
        n_fail++; $display("FAIL rnd_sat@%0d: got %0d/%0d want %0d/%0d", i, s_scnt, s_fcnt,
                           sat2(m_stalls), sat2(m_flushes)); end
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_redirect();
    test_back_to_back();
    test_reset_mid_flush();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
